self_healing_controller: RTL and testbench

Recovery stage directly downstream of the fault detection unit in the train reservation datapath. It consumes the registered `fault_flag` together with the same `booked_count`/`fare` values the detector evaluates, and keeps a checkpoint of the last state confirmed fault-free. When a fault persists, it drives a rollback of the booking registers to that checkpoint, retries a bounded number of times, and escalates to a lockout that only an operator can clear.

---
 rtl/self_healing_controller.sv | 145 ++++++++++++++
 tb/tb_self_healing_controller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/self_healing_controller.sv
// Fault recovery stage: checkpoints fault-free booking state, rolls back on a
// persistent fault, retries a bounded number of times, then locks out.
module self_healing_controller #(
    parameter int unsigned FAULT_PERSIST = 2,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fault_flag,
    input  logic [3:0] booked_count,
    input  logic [9:0] fare,
    input  logic       clear_lockout,
    output logic       restore_en,
    output logic [3:0] restore_count,
    output logic [9:0] restore_fare,
    output logic       booking_hold,
    output logic       lockout,
    output logic [2:0] retry_count,
    output logic [7:0] fault_events
);

    typedef enum logic [2:0] {
        ST_NORMAL,
        ST_CONFIRM,
        ST_RESTORE,
        ST_SETTLE,
        ST_LOCKOUT
    } state_t;

    localparam logic [2:0] PERSIST_LIM = 3'(FAULT_PERSIST);
    localparam logic [3:0] SETTLE_LD   = 4'(SETTLE_CYCLES);
    localparam logic [2:0] RETRY_LIM   = 3'(MAX_RETRIES);

    state_t      state_q, state_d;
    logic [13:0] stage_q, stage_d;
    logic [13:0] checkpoint_q, checkpoint_d;
    logic [2:0]  persist_q, persist_d;
    logic [2:0]  retry_q, retry_d;
    logic [7:0]  events_q, events_d;
    logic [3:0]  timer_q, timer_d;
    logic        restore_en_q, restore_en_d;
    logic        hold_q, hold_d;
    logic        lockout_q, lockout_d;

    always_comb begin
        state_d      = state_q;
        stage_d      = {booked_count, fare};
        checkpoint_d = checkpoint_q;
        persist_d    = persist_q;
        retry_d      = retry_q;
        events_d     = events_q;
        timer_d      = timer_q;

        unique case (state_q)
            ST_NORMAL: begin
                if (!fault_flag) begin
                    checkpoint_d = stage_q;
                    persist_d    = '0;
                end else begin
                    persist_d = 3'd1;
                    state_d   = (FAULT_PERSIST == 1) ? ST_RESTORE : ST_CONFIRM;
                end
            end
            ST_CONFIRM: begin
                if (!fault_flag) begin
                    persist_d = '0;
                    state_d   = ST_NORMAL;
                end else begin
                    persist_d = persist_q + 3'd1;
                    if (persist_q + 3'd1 >= PERSIST_LIM) state_d = ST_RESTORE;
                end
            end
            ST_RESTORE: begin
                persist_d = '0;
                retry_d   = retry_q + 3'd1;
                if (events_q != 8'hFF) events_d = events_q + 8'd1;
                timer_d   = SETTLE_LD;
                state_d   = ST_SETTLE;
            end
            ST_SETTLE: begin
                // The edge that sees timer==1 closes the settle window and samples the fault.
                if (timer_q <= 4'd1) begin
                    timer_d = '0;
                    if (!fault_flag) begin
                        retry_d = '0;
                        state_d = ST_NORMAL;
                    end else if (retry_q >= RETRY_LIM) begin
                        state_d = ST_LOCKOUT;
                    end else begin
                        state_d = ST_RESTORE;
                    end
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            ST_LOCKOUT: begin
                if (clear_lockout) begin
                    retry_d = '0;
                    state_d = ST_NORMAL;
                end
            end
            default: state_d = ST_NORMAL;
        endcase

        restore_en_d = (state_d == ST_RESTORE);
        hold_d       = (state_d != ST_NORMAL);
        lockout_d    = (state_d == ST_LOCKOUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_NORMAL;
            stage_q      <= '0;
            checkpoint_q <= '0;
            persist_q    <= '0;
            retry_q      <= '0;
            events_q     <= '0;
            timer_q      <= '0;
            restore_en_q <= 1'b0;
            hold_q       <= 1'b0;
            lockout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            checkpoint_q <= checkpoint_d;
            persist_q    <= persist_d;
            retry_q      <= retry_d;
            events_q     <= events_d;
            timer_q      <= timer_d;
            restore_en_q <= restore_en_d;
            hold_q       <= hold_d;
            lockout_q    <= lockout_d;
        end
    end

    assign restore_en    = restore_en_q;
    assign booking_hold  = hold_q;
    assign lockout       = lockout_q;
    assign retry_count   = retry_q;
    assign fault_events  = events_q;
    assign restore_count = checkpoint_q[13:10];
    assign restore_fare  = checkpoint_q[9:0];

endmodule

// File: tb/tb_self_healing_controller.sv
// Directed bench for self_healing_controller with default parameters.
module tb_self_healing_controller;

    logic       clk;
    logic       rst;
    logic       fault_flag;
    logic [3:0] booked_count;
    logic [9:0] fare;
    logic       clear_lockout;
    logic       restore_en;
    logic [3:0] restore_count;
    logic [9:0] restore_fare;
    logic       booking_hold;
    logic       lockout;
    logic [2:0] retry_count;
    logic [7:0] fault_events;

    int checks   = 0;
    int failures = 0;

    self_healing_controller #(
        .FAULT_PERSIST(2),
        .SETTLE_CYCLES(4),
        .MAX_RETRIES(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fault_flag(fault_flag),
        .booked_count(booked_count),
        .fare(fare),
        .clear_lockout(clear_lockout),
        .restore_en(restore_en),
        .restore_count(restore_count),
        .restore_fare(restore_fare),
        .booking_hold(booking_hold),
        .lockout(lockout),
        .retry_count(retry_count),
        .fault_events(fault_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle 1ns so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_restore_en"}, 32'(restore_en), 0);
        check_eq({tag, "_hold"}, 32'(booking_hold), 0);
        check_eq({tag, "_lockout"}, 32'(lockout), 0);
        check_eq({tag, "_retry"}, 32'(retry_count), 0);
        check_eq({tag, "_events"}, 32'(fault_events), 0);
        check_eq({tag, "_rcount"}, 32'(restore_count), 0);
        check_eq({tag, "_rfare"}, 32'(restore_fare), 0);
    endtask

    int pulses;
    int pulse_at [3];
    int lock_at;
    int retry_at_lock;

    initial begin
        rst           = 1'b1;
        fault_flag    = 1'b0;
        booked_count  = 4'd0;
        fare          = 10'd0;
        clear_lockout = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Clean checkpoint: visible two edges after being presented.
        booked_count = 4'd5;
        fare         = 10'd300;
        tick();
        check_eq("ckpt_early_count", 32'(restore_count), 0);
        tick();
        check_eq("ckpt_count", 32'(restore_count), 5);
        check_eq("ckpt_fare", 32'(restore_fare), 300);
        check_eq("ckpt_hold", 32'(booking_hold), 0);

        // Transient one-cycle fault.
        fault_flag = 1'b1;
        tick();
        check_eq("trans_hold_hi", 32'(booking_hold), 1);
        check_eq("trans_restore_en", 32'(restore_en), 0);
        fault_flag = 1'b0;
        tick();
        check_eq("trans_hold_lo", 32'(booking_hold), 0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (restore_en) pulses++;
        end
        check_eq("trans_no_restore", 32'(pulses), 0);
        check_eq("trans_events", 32'(fault_events), 0);

        // Recovery: 3-cycle fault with corrupted inputs, rollback, clean settle.
        booked_count = 4'd12;
        fare         = 10'd950;
        fault_flag   = 1'b1;
        tick();
        check_eq("rec_confirm_hold", 32'(booking_hold), 1);
        check_eq("rec_confirm_ren", 32'(restore_en), 0);
        tick();
        check_eq("rec_restore_en", 32'(restore_en), 1);
        check_eq("rec_restore_count", 32'(restore_count), 5);
        check_eq("rec_restore_fare", 32'(restore_fare), 300);
        booked_count = 4'd5;
        fare         = 10'd300;
        tick();
        check_eq("rec_settle_ren", 32'(restore_en), 0);
        check_eq("rec_settle_retry", 32'(retry_count), 1);
        check_eq("rec_settle_events", 32'(fault_events), 1);
        fault_flag = 1'b0;
        tick();
        tick();
        tick();
        check_eq("rec_settle_hold", 32'(booking_hold), 1);
        tick();
        check_eq("rec_normal_hold", 32'(booking_hold), 0);
        check_eq("rec_retry_clear", 32'(retry_count), 0);
        check_eq("rec_events", 32'(fault_events), 1);
        check_eq("rec_ckpt_count", 32'(restore_count), 5);
        check_eq("rec_ckpt_fare", 32'(restore_fare), 300);
        tick();

        // Persistent fault: three restores 5 cycles apart, lockout at edge e+16.
        pulses = 0;
        lock_at = -1;
        retry_at_lock = -1;
        for (int k = 0; k < 3; k++) pulse_at[k] = -1;
        fault_flag = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (restore_en) begin
                if (pulses < 3) pulse_at[pulses] = i;
                pulses++;
            end
            if (lockout && lock_at < 0) begin
                lock_at = i;
                retry_at_lock = int'(retry_count);
            end
        end
        check_eq("lock_pulses", 32'(pulses), 3);
        check_eq("lock_pulse0", 32'(pulse_at[0]), 1);
        check_eq("lock_pulse1", 32'(pulse_at[1]), 6);
        check_eq("lock_pulse2", 32'(pulse_at[2]), 11);
        check_eq("lock_edge", 32'(lock_at), 16);
        check_eq("lock_retry", 32'(retry_at_lock), 3);
        check_eq("lock_hold", 32'(booking_hold), 1);
        check_eq("lock_events", 32'(fault_events), 4);
        fault_flag    = 1'b0;
        clear_lockout = 1'b1;
        tick();
        clear_lockout = 1'b0;
        check_eq("clear_lockout", 32'(lockout), 0);
        check_eq("clear_hold", 32'(booking_hold), 0);
        check_eq("clear_retry", 32'(retry_count), 0);
        check_eq("clear_events", 32'(fault_events), 4);
        check_eq("clear_ckpt", 32'(restore_count), 5);

        // Reset while in SETTLE.
        fault_flag = 1'b1;
        tick();
        tick();
        tick();
        check_eq("midrst_in_settle", 32'(booking_hold), 1);
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst        = 1'b0;
        fault_flag = 1'b0;
        tick();
        check_eq("midrst_after_hold", 32'(booking_hold), 0);

        // Saturation of fault_events over 256 episodes.
        for (int n = 0; n < 256; n++) begin
            fault_flag = 1'b1;
            tick();
            tick();
            fault_flag = 1'b0;
            for (int j = 0; j < 5; j++) tick();
            tick();
            if (n == 253) check_eq("sat_254", 32'(fault_events), 254);
            if (n == 254) check_eq("sat_255", 32'(fault_events), 255);
        end
        check_eq("sat_hold_255", 32'(fault_events), 255);
        check_eq("sat_hold_lo", 32'(booking_hold), 0);
        check_eq("sat_retry", 32'(retry_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
